cpu_boot_debug_ctrl: RTL

Boot and debug controller placed between the host or bench and the CPU core. It streams a program into instruction memory over a valid/ready handshake, holding the CPU in reset while it does so. It then releases the CPU in one of three modes: run-to-end/limit, single-step, or run-to-breakpoint. It counts released cycles and reports why execution halted. This makes program loading and execution-window control a reusable hardware block rather than manual hierarchical pokes and fixed delays.

---
 rtl/cpu_boot_debug_ctrl.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_boot_debug_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_boot_debug_ctrl
// Boot and debug controller that sits between a host and a CPU core.
// It streams a program into instruction memory while the CPU is held in reset.
// It then releases the CPU in run, single-step or run-to-breakpoint mode,
// counts the released cycles and records why execution stopped.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   load_valid/ready    program word handshake (load_data, load_last)
//   imem_we/addr/wdata  zero-latency instruction memory write port
//   mode                00 run, 01 single-step, 10 run-to-breakpoint, 11 = 00
//   start/step/clear    one-cycle control pulses
//   cycle_limit         max released cycles (0 = unlimited)
//   bp_addr, cpu_pc     breakpoint PC and observed CPU PC
//   cpu_hold            1 = CPU held in reset
//   prog_len            number of words loaded
//   cycle_count         released cycles (saturating)
//   halted, done_cause  halt status and cause (01 END, 10 BREAK, 11 LIMIT)
//   overflow            sticky: load truncated at imem capacity
// -----------------------------------------------------------------------------
module cpu_boot_debug_ctrl #(
    parameter int INSTR_WIDTH = 18,
    parameter int ADDR_WIDTH  = 10,
    parameter int PC_WIDTH    = 10,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   load_last,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    input  logic [1:0]             mode,
    input  logic                   start,
    input  logic                   step,
    input  logic                   clear,
    input  logic [CNT_WIDTH-1:0]   cycle_limit,
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic [PC_WIDTH-1:0]    cpu_pc,
    output logic                   cpu_hold,
    output logic [ADDR_WIDTH:0]    prog_len,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic                   halted,
    output logic [1:0]             done_cause,
    output logic                   overflow
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CMP_W = PC_WIDTH + ADDR_WIDTH + 1;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_END   = 2'b01;
    localparam logic [1:0] CAUSE_BREAK = 2'b10;
    localparam logic [1:0] CAUSE_LIMIT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ARMED     = 3'd2,
        ST_RUN       = 3'd3,
        ST_STEP_WAIT = 3'd4,
        ST_STEP_GO   = 3'd5,
        ST_HALT      = 3'd6
    } state_t;

    // Cycle counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == {CNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    state_t                 state_r, state_s;
    logic [ADDR_WIDTH-1:0]  ptr_r, ptr_s;
    logic [LEN_W-1:0]       len_r, len_s;
    logic [CNT_WIDTH-1:0]   cnt_r, cnt_s;
    logic [1:0]             cause_r, cause_s;
    logic                   ovf_r, ovf_s;
    logic [1:0]             mode_r, mode_s;

    logic                   accept_s;
    logic                   ptr_full_s;
    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic                   hit_break_s;
    logic                   hit_end_s;
    logic                   hit_limit_s;

    // Handshake, write port and status decode straight from the state register
    // so cpu_hold follows the asynchronous reset without waiting for an edge.
    always_comb begin
        load_ready  = (state_r == ST_IDLE) || (state_r == ST_LOAD);
        accept_s    = load_valid & load_ready;
        imem_we     = accept_s;
        imem_addr   = ptr_r;
        imem_wdata  = load_data;
        cpu_hold    = !((state_r == ST_RUN) || (state_r == ST_STEP_GO));
        halted      = (state_r == ST_HALT);
        prog_len    = len_r;
        cycle_count = cnt_r;
        done_cause  = cause_r;
        overflow    = ovf_r;
    end

    // Halt condition evaluation against the current PC and post-increment count.
    always_comb begin
        ptr_full_s  = (ptr_r == {ADDR_WIDTH{1'b1}});
        cnt_inc_s   = sat_inc(cnt_r);
        // Mode is latched at start so a mid-run change cannot alter the rules.
        hit_break_s = (mode_r == 2'b10) && (cpu_pc == bp_addr);
        hit_end_s   = (CMP_W'(cpu_pc) >= CMP_W'(len_r));
        hit_limit_s = (cycle_limit != {CNT_WIDTH{1'b0}}) && (cnt_inc_s == cycle_limit);
    end

    // Next-state and next-register computation for the controller.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        len_s   = len_r;
        cnt_s   = cnt_r;
        cause_s = cause_r;
        ovf_s   = ovf_r;
        mode_s  = mode_r;
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (accept_s) begin
                    ptr_s = ptr_r + ADDR_WIDTH'(1);
                    len_s = len_r + LEN_W'(1);
                    if (load_last) begin
                        state_s = ST_ARMED;
                    end else if (ptr_full_s) begin
                        // Memory is full: arm with what fits and flag truncation.
                        state_s = ST_ARMED;
                        ovf_s   = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_ARMED: begin
                if (start) begin
                    cnt_s   = {CNT_WIDTH{1'b0}};
                    mode_s  = mode;
                    state_s = (mode == 2'b01) ? ST_STEP_WAIT : ST_RUN;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                cnt_s = cnt_inc_s;
                if (hit_break_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_BREAK;
                end else if (hit_end_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_END;
                end else if (hit_limit_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_LIMIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_STEP_WAIT: begin
                if (step) begin
                    state_s = ST_STEP_GO;
                end else begin
                    state_s = ST_STEP_WAIT;
                end
            end
            ST_STEP_GO: begin
                // Single released cycle; a step pulse seen here is dropped.
                cnt_s = cnt_inc_s;
                if (hit_end_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_END;
                end else if (hit_limit_s) begin
                    state_s = ST_HALT;
                    cause_s = CAUSE_LIMIT;
                end else begin
                    state_s = ST_STEP_WAIT;
                end
            end
            ST_HALT: begin
                if (clear) begin
                    state_s = ST_IDLE;
                    ptr_s   = {ADDR_WIDTH{1'b0}};
                    len_s   = {LEN_W{1'b0}};
                    cnt_s   = {CNT_WIDTH{1'b0}};
                    cause_s = CAUSE_NONE;
                    ovf_s   = 1'b0;
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Controller state and bookkeeping registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= {ADDR_WIDTH{1'b0}};
            len_r   <= {LEN_W{1'b0}};
            cnt_r   <= {CNT_WIDTH{1'b0}};
            cause_r <= CAUSE_NONE;
            ovf_r   <= 1'b0;
            mode_r  <= 2'b00;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            len_r   <= len_s;
            cnt_r   <= cnt_s;
            cause_r <= cause_s;
            ovf_r   <= ovf_s;
            mode_r  <= mode_s;
        end
    end

endmodule
